// File: rtl/urna_multicandidato.sv
// urna_multicandidato: multi-candidate ballot box with BCD code entry.
// Optional: define BLANK_VOTE_EN to count code 0 in a separate blank total.
module urna_multicandidato #(
    parameter int NUM_CAND   = 4,
    parameter int NUM_DIGITS = 2,
    parameter int CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                digit,
    input  logic                      valid,
    input  logic                      swap,
    input  logic                      confirm,
    input  logic                      finish,
    output logic [1:0]                vote_status,
    output logic [4*NUM_DIGITS-1:0]   entry_code,
    output logic [NUM_CAND*CNT_W-1:0] total_cand,
    output logic [CNT_W-1:0]          total_null,
    output logic [CNT_W-1:0]          total_blank,
    output logic [2:0]                state_o,
    output logic                      sat
);
    localparam int VAL_W = 4*NUM_DIGITS;
    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic [2:0] {
        FECHADA   = 3'd0,
        AGUARDA   = 3'd1,
        DIGITANDO = 3'd2,
        CONFIRMA  = 3'd3,
        ENCERRADA = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [VAL_W-1:0] entry_q, entry_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] cand_q [NUM_CAND];
    logic [CNT_W-1:0] cand_d [NUM_CAND];
    logic [CNT_W-1:0] null_q, null_d;
    logic             sat_q, sat_d;
    logic [VAL_W-1:0] val;
    logic             is_open;
    logic             hit;
`ifdef BLANK_VOTE_EN
    logic [CNT_W-1:0] blank_q, blank_d;
`endif

    assign is_open = (state_q == AGUARDA) || (state_q == DIGITANDO) ||
                     (state_q == CONFIRMA);

    // Decimal value of the entry, first digit most significant
    always_comb begin
        val = '0;
        for (int k = NUM_DIGITS-1; k >= 0; k--)
            val = VAL_W'(val * VAL_W'(10)) + VAL_W'(entry_q[k*4 +: 4]);
    end

    // Next state, entry and counters; priority finish > start > swap > confirm > valid
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        status_d = 2'b00;
        null_d   = null_q;
        sat_d    = sat_q;
        hit      = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) cand_d[i] = cand_q[i];
`ifdef BLANK_VOTE_EN
        blank_d  = blank_q;
`endif
        if (is_open && finish) begin
            state_d = ENCERRADA;
            entry_d = '0;
            cnt_d   = '0;
        end else if (!is_open && start) begin
            state_d = AGUARDA;
            entry_d = '0;
            cnt_d   = '0;
            null_d  = '0;
            sat_d   = 1'b0;
            for (int i = 0; i < NUM_CAND; i++) cand_d[i] = '0;
`ifdef BLANK_VOTE_EN
            blank_d = '0;
`endif
        end else if (is_open && swap) begin
            state_d  = AGUARDA;
            entry_d  = '0;
            cnt_d    = '0;
            status_d = 2'b10;
        end else if (state_q == CONFIRMA && confirm) begin
            state_d  = AGUARDA;
            entry_d  = '0;
            cnt_d    = '0;
            status_d = 2'b01;
            for (int i = 0; i < NUM_CAND; i++) begin
                if (val == VAL_W'(i+1)) begin
                    hit = 1'b1;
                    if (cand_q[i] != MAX) begin
                        cand_d[i] = cand_q[i] + 1'b1;
                        sat_d = sat_q | (cand_d[i] == MAX);
                    end
                end
            end
            if (!hit) begin
`ifdef BLANK_VOTE_EN
                if (val == '0) begin
                    if (blank_q != MAX) begin
                        blank_d = blank_q + 1'b1;
                        sat_d = sat_q | (blank_d == MAX);
                    end
                end else if (null_q != MAX) begin
                    null_d = null_q + 1'b1;
                    sat_d = sat_q | (null_d == MAX);
                end
`else
                if (null_q != MAX) begin
                    null_d = null_q + 1'b1;
                    sat_d = sat_q | (null_d == MAX);
                end
`endif
            end
        end else if ((state_q == AGUARDA || state_q == DIGITANDO) && valid) begin
            if (digit > 4'd9) begin
                status_d = 2'b11;
            end else begin
                for (int k = 0; k < NUM_DIGITS; k++)
                    if (cnt_q == 2'(k))
                        entry_d[(NUM_DIGITS-1-k)*4 +: 4] = digit;
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'(NUM_DIGITS-1)) ? CONFIRMA : DIGITANDO;
            end
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FECHADA;
            entry_q  <= '0;
            cnt_q    <= '0;
            status_q <= 2'b00;
            null_q   <= '0;
            sat_q    <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) cand_q[i] <= '0;
`ifdef BLANK_VOTE_EN
            blank_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            null_q   <= null_d;
            sat_q    <= sat_d;
            for (int i = 0; i < NUM_CAND; i++) cand_q[i] <= cand_d[i];
`ifdef BLANK_VOTE_EN
            blank_q  <= blank_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_tot
        assign total_cand[g*CNT_W +: CNT_W] = cand_q[g];
    end

`ifdef BLANK_VOTE_EN
    assign total_blank = blank_q;
`else
    assign total_blank = '0;
`endif
    assign vote_status = status_q;
    assign entry_code  = entry_q;
    assign total_null  = null_q;
    assign state_o     = state_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_urna_multicandidato.sv
// tb_urna_multicandidato: directed plus random stimulus against a
// digit-queue reference model of the ballot box.
module tb_urna_multicandidato;
    localparam int NC   = 4;
    localparam int ND   = 2;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, valid = 1'b0;
    logic swap = 1'b0, confirm = 1'b0, finish = 1'b0;
    logic [3:0] digit = 4'd0;
    logic [1:0] vote_status;
    logic [4*ND-1:0] entry_code;
    logic [NC*CW-1:0] total_cand;
    logic [CW-1:0] total_null, total_blank;
    logic [2:0] state_o;
    logic sat;

    urna_multicandidato #(.NUM_CAND(NC), .NUM_DIGITS(ND), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .digit(digit), .valid(valid),
        .swap(swap), .confirm(confirm), .finish(finish),
        .vote_status(vote_status), .entry_code(entry_code),
        .total_cand(total_cand), .total_null(total_null),
        .total_blank(total_blank), .state_o(state_o), .sat(sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: election open flag, entered digits, plain totals
    bit m_open, m_ended, m_sat;
    int m_q[$];
    int m_cand[NC];
    int m_null, m_blank, m_status;

    function automatic int inc(int c);
        if (c < MAXV) begin
            c++;
            if (c == MAXV) m_sat = 1'b1;
        end
        return c;
    endfunction

    function automatic void m_clear_totals();
        for (int i = 0; i < NC; i++) m_cand[i] = 0;
        m_null = 0;
        m_blank = 0;
        m_sat = 1'b0;
    endfunction

    function automatic int m_state();
        if (!m_open) return m_ended ? 4 : 0;
        if (m_q.size() == 0) return 1;
        if (m_q.size() < ND) return 2;
        return 3;
    endfunction

    function automatic logic [4*ND-1:0] m_entry();
        logic [4*ND-1:0] e = '0;
        for (int k = 0; k < m_q.size(); k++)
            e[(ND-1-k)*4 +: 4] = 4'(m_q[k]);
        return e;
    endfunction

    function automatic void m_vote();
        int v = 0;
        foreach (m_q[k]) v = v * 10 + m_q[k];
        if (v >= 1 && v <= NC) m_cand[v-1] = inc(m_cand[v-1]);
`ifdef BLANK_VOTE_EN
        else if (v == 0) m_blank = inc(m_blank);
`endif
        else m_null = inc(m_null);
    endfunction

    function automatic void m_step(bit r, bit st, int d, bit v,
                                   bit sw, bit cf, bit fn);
        m_status = 0;
        if (r) begin
            m_open = 0;
            m_ended = 0;
            m_q.delete();
            m_clear_totals();
        end else if (m_open && fn) begin
            m_open = 0;
            m_ended = 1;
            m_q.delete();
        end else if (!m_open && st) begin
            m_open = 1;
            m_q.delete();
            m_clear_totals();
        end else if (m_open && sw) begin
            m_q.delete();
            m_status = 2;
        end else if (m_open && m_q.size() == ND && cf) begin
            m_vote();
            m_q.delete();
            m_status = 1;
        end else if (m_open && m_q.size() < ND && v) begin
            if (d > 9) m_status = 3;
            else m_q.push_back(d);
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("vote_status", 32'(vote_status), m_status);
        chk("entry_code", 32'(entry_code), 32'(m_entry()));
        chk("state_o", 32'(state_o), m_state());
        for (int i = 0; i < NC; i++)
            chk($sformatf("total_cand[%0d]", i),
                32'(total_cand[i*CW +: CW]), m_cand[i]);
        chk("total_null", 32'(total_null), m_null);
        chk("total_blank", 32'(total_blank), m_blank);
        chk("sat", 32'(sat), 32'(m_sat));
    endtask

    task automatic step(bit r, bit st, int d, bit v, bit sw, bit cf, bit fn);
        @(negedge clk);
        rst = r; start = st; digit = 4'(d); valid = v;
        swap = sw; confirm = cf; finish = fn;
        @(posedge clk);
        m_step(r, st, d, v, sw, cf, fn);
        #1;
        check_all();
        rst = 0; start = 0; valid = 0; swap = 0; confirm = 0; finish = 0;
    endtask

    task automatic dig(int d);  step(0, 0, d, 1, 0, 0, 0); endtask
    task automatic conf();      step(0, 0, 0, 0, 0, 1, 0); endtask
    task automatic go();        step(0, 1, 0, 0, 0, 0, 0); endtask
    task automatic idle();      step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic reset_dut(); step(1, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        bit r, st, v, sw, cf, fn;
        int d;
        m_open = 0; m_ended = 0; m_status = 0;
        m_clear_totals();

        reset_dut();
        go(); dig(0); dig(3); conf(); idle();

        go(); dig(9); dig(9); conf();
        dig(0); dig(0); conf(); idle();

        dig(0); dig(12); dig(1); step(0, 0, 0, 0, 1, 0, 0); idle();

        reset_dut(); go();
        for (int n = 0; n < 256; n++) begin
            dig(0); dig(1); conf();
        end
        idle();

        dig(0); dig(2); step(0, 0, 0, 0, 0, 1, 1);
        dig(1); conf(); dig(0); idle();
        go();

        dig(0); dig(1); step(0, 0, 0, 0, 1, 1, 0);
        dig(3); step(1, 0, 0, 1, 0, 0, 0);
        go();

        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom % 500) == 0;
            fn = ($urandom % 80) == 0;
            st = ($urandom % 30) == 0;
            sw = ($urandom % 15) == 0;
            cf = ($urandom % 4) == 0;
            v  = ($urandom % 2) == 0;
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11)
                                             : $urandom_range(0, 4);
            step(r, st, d, v, sw, cf, fn);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
